// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-back, write-allocate data cache
`timescale 1ns/1ps
module dcache #(
    parameter int ADDR_W   = 64,
    parameter int WORD_W   = 64,
    parameter int BLOCK_W  = 512,
    parameter int NUM_SETS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  r_addr,
    input  logic [ADDR_W-1:0]  w_addr,
    input  logic [WORD_W-1:0]  data_in,
    output logic [WORD_W-1:0]  data_out,
    output logic               operation_complete,
    output logic [ADDR_W-1:0]  mem_address,
    output logic [BLOCK_W-1:0] mem_data_out,
    output logic               mem_wr_en,
    output logic               mem_rd_en,
    input  logic [BLOCK_W-1:0] mem_data_in,
    input  logic               mem_data_valid
);
    localparam int OFF_W  = $clog2(BLOCK_W / 8);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int SEL_W  = $clog2(BLOCK_W / WORD_W);
    localparam int BYTE_W = $clog2(WORD_W / 8);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, RESPOND} state_t;

    state_t              state;
    logic                req_wr;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    req_tag;
    logic [SEL_W-1:0]    req_sel;
    logic [WORD_W-1:0]   req_data;

    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;
    logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
    logic [BLOCK_W-1:0]  line_mem [NUM_SETS];

    logic [ADDR_W-1:0]   in_addr;
    logic [IDX_W-1:0]    in_idx;
    logic [TAG_W-1:0]    in_tag;
    logic [SEL_W-1:0]    in_sel;
    logic                in_hit;
    logic                in_dirty_victim;
    logic [BLOCK_W-1:0]  req_line;
    logic [WORD_W-1:0]   req_word;
    logic                unused_bits;

    // Decode the incoming request against the tag store (used only in IDLE)
    always_comb begin
        in_addr         = wr_en ? w_addr : r_addr;
        in_idx          = in_addr[OFF_W +: IDX_W];
        in_tag          = in_addr[ADDR_W-1 -: TAG_W];
        in_sel          = in_addr[BYTE_W +: SEL_W];
        in_hit          = valid[in_idx] && (tag_mem[in_idx] == in_tag);
        in_dirty_victim = valid[in_idx] && dirty[in_idx];
        req_line        = line_mem[req_idx];
        req_word        = req_line[req_sel*WORD_W +: WORD_W];
        unused_bits     = ^in_addr[BYTE_W-1:0];
    end

    // Control FSM: request latch, valid/dirty bits and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            req_wr             <= 1'b0;
            req_idx            <= '0;
            req_tag            <= '0;
            req_sel            <= '0;
            req_data           <= '0;
            valid              <= '0;
            dirty              <= '0;
            data_out           <= '0;
            operation_complete <= 1'b0;
            mem_address        <= '0;
            mem_data_out       <= '0;
            mem_wr_en          <= 1'b0;
            mem_rd_en          <= 1'b0;
        end else begin
            operation_complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        req_wr   <= wr_en;
                        req_idx  <= in_idx;
                        req_tag  <= in_tag;
                        req_sel  <= in_sel;
                        req_data <= data_in;
                        if (in_hit) begin
                            state <= RESPOND;
                        end else if (in_dirty_victim) begin
                            state        <= WRITEBACK;
                            mem_wr_en    <= 1'b1;
                            mem_address  <= {tag_mem[in_idx], in_idx, {OFF_W{1'b0}}};
                            mem_data_out <= line_mem[in_idx];
                        end else begin
                            state       <= FILL;
                            mem_rd_en   <= 1'b1;
                            mem_address <= {in_tag, in_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_data_valid) begin
                        mem_wr_en      <= 1'b0;
                        dirty[req_idx] <= 1'b0;
                        mem_rd_en      <= 1'b1;
                        mem_address    <= {req_tag, req_idx, {OFF_W{1'b0}}};
                        state          <= FILL;
                    end
                end
                FILL: begin
                    if (mem_data_valid) begin
                        mem_rd_en      <= 1'b0;
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        state          <= RESPOND;
                    end
                end
                RESPOND: begin
                    operation_complete <= 1'b1;
                    if (req_wr) begin
                        dirty[req_idx] <= 1'b1;
                    end else begin
                        data_out <= req_word;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and line storage: install on fill ack, merge store word on respond
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL && mem_data_valid) begin
                line_mem[req_idx] <= mem_data_in;
                tag_mem[req_idx]  <= req_tag;
            end else if (state == RESPOND && req_wr) begin
                line_mem[req_idx][req_sel*WORD_W +: WORD_W] <= req_data;
            end
        end
    end
endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - self-checking bench for dcache with flat-memory reference model
`timescale 1ns/1ps
module tb_dcache;
    logic         clk = 1'b0;
    logic         rst;
    logic         enable, wr_en;
    logic [63:0]  r_addr, w_addr, data_in, data_out, mem_address;
    logic         operation_complete, mem_wr_en, mem_rd_en, mem_data_valid;
    logic [511:0] mem_data_out, mem_data_in;

    dcache dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en),
        .r_addr(r_addr), .w_addr(w_addr), .data_in(data_in), .data_out(data_out),
        .operation_complete(operation_complete), .mem_address(mem_address),
        .mem_data_out(mem_data_out), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // backing memory (line granular) and CPU-visible flat word memory
    logic [511:0] bmem [logic [63:0]];
    logic [63:0]  fmem [logic [63:0]];
    // set-occupancy model used only to predict memory traffic
    bit           mv [64];
    bit           md [64];
    logic [51:0]  mt [64];
    logic [63:0]  last_load;

    int           mem_delay = 0;
    int           trans_rd, trans_wr, stab_err, both_err;
    logic [63:0]  last_wb_addr, last_rd_addr;
    logic [511:0] last_wb_data;

    function automatic logic [511:0] init_line(logic [63:0] la);
        logic [511:0] l;
        for (int k = 0; k < 8; k++)
            l[k*64 +: 64] = (la + 64'(k * 8)) ^ 64'hC0FF_EE00_0000_0000;
        if (la == 64'h1000) begin
            l[63:0]   = 64'hAAAA;
            l[127:64] = 64'hBBBB;
        end
        return l;
    endfunction

    function automatic logic [63:0] ref_word(logic [63:0] a);
        logic [63:0]  wa;
        logic [511:0] l;
        wa = a & ~64'h7;
        if (fmem.exists(wa)) return fmem[wa];
        l = init_line(a & ~64'h3F);
        return l[a[5:3]*64 +: 64];
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // memory responder: acks each request after mem_delay wait cycles
    initial begin : responder
        bit          pending;
        int          wait_cnt;
        logic [63:0] t_addr;
        logic        t_rd;
        pending = 0;
        wait_cnt = 0;
        t_addr = '0;
        t_rd = 0;
        mem_data_valid = 1'b0;
        mem_data_in = '0;
        stab_err = 0;
        both_err = 0;
        forever begin
            @(negedge clk);
            mem_data_valid = 1'b0;
            if (mem_rd_en && mem_wr_en) both_err++;
            if (mem_rd_en || mem_wr_en) begin
                if (!pending) begin
                    pending = 1;
                    wait_cnt = 0;
                    t_addr = mem_address;
                    t_rd = mem_rd_en;
                end else if (mem_address !== t_addr || mem_rd_en !== t_rd) begin
                    stab_err++;
                end
                if (wait_cnt >= mem_delay) begin
                    pending = 0;
                    mem_data_valid = 1'b1;
                    if (t_rd) begin
                        mem_data_in = bmem.exists(t_addr) ? bmem[t_addr] : init_line(t_addr);
                        last_rd_addr = t_addr;
                        trans_rd++;
                    end else begin
                        bmem[t_addr] = mem_data_out;
                        last_wb_addr = t_addr;
                        last_wb_data = mem_data_out;
                        trans_wr++;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                pending = 0;
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic model_reset();
        for (int s = 0; s < 64; s++) begin
            mv[s] = 0;
            md[s] = 0;
        end
        last_load = '0;
    endtask

    task automatic predict(input bit wr, input logic [63:0] a, input logic [63:0] d,
                           input int dly, output logic [63:0] q, output int lat,
                           output int nrd, output int nwr);
        int  s;
        bit  hit;
        s = int'(a[11:6]);
        hit = mv[s] && (mt[s] == a[63:12]);
        nrd = hit ? 0 : 1;
        nwr = (!hit && mv[s] && md[s]) ? 1 : 0;
        if (!hit) begin
            mv[s] = 1;
            mt[s] = a[63:12];
            md[s] = 0;
        end
        if (wr) begin
            md[s] = 1;
            fmem[a & ~64'h7] = d;
            q = last_load;
        end else begin
            q = ref_word(a);
            last_load = q;
        end
        lat = 2 + (nrd + nwr) * (1 + dly);
    endtask

    task automatic exec(input bit wr, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] q, output int lat);
        bit done;
        @(negedge clk);
        trans_rd = 0;
        trans_wr = 0;
        enable = 1'b1;
        wr_en = wr;
        r_addr = wr ? 64'($urandom) : a;
        w_addr = wr ? a : 64'($urandom);
        data_in = d;
        @(posedge clk);
        #1 enable = 1'b0;
        lat = 0;
        done = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (operation_complete) done = 1;
        end
        if (!done) chk("op_timeout", 64'(done), 64'd1);
        q = data_out;
        @(negedge clk);
        chk("complete_pulse_width", 64'(operation_complete), 64'd0);
    endtask

    typedef struct {
        bit          wr;
        logic [63:0] addr;
        logic [63:0] data;
        int          delay;
        logic [63:0] exp_q;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [63:0] exp_wb_addr;
        logic [63:0] exp_wb_w0;
    } vec_t;

    initial begin : main
        vec_t        tbl [6];
        logic [63:0] q, eq;
        int          lat, elat, erd, ewr, cnt;

        tbl[0] = '{0, 64'h1000, 0, 0, 64'hAAAA, 3, 1, 0, 0, 0};
        tbl[1] = '{0, 64'h1008, 0, 0, 64'hBBBB, 2, 0, 0, 0, 0};
        tbl[2] = '{1, 64'h1000, 64'h1234, 0, 64'hBBBB, 2, 0, 0, 0, 0};
        tbl[3] = '{0, 64'h2000, 0, 0, 64'hC0FFEE0000002000, 4, 1, 1, 64'h1000, 64'h1234};
        tbl[4] = '{0, 64'h1000, 0, 0, 64'h1234, 3, 1, 0, 0, 0};
        tbl[5] = '{0, 64'h1048, 0, 3, 64'hC0FFEE0000001048, 6, 1, 0, 0, 0};

        rst = 1'b1;
        enable = 1'b0;
        wr_en = 1'b0;
        r_addr = '0;
        w_addr = '0;
        data_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_complete", 64'(operation_complete), 64'd0);
        chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_mem_address", mem_address, 64'd0);
        chk("rst_mem_data_out_zero", 64'(mem_data_out == '0), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 6; i++) begin
            mem_delay = tbl[i].delay;
            predict(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].delay, eq, elat, erd, ewr);
            exec(tbl[i].wr, tbl[i].addr, tbl[i].data, q, lat);
            chk($sformatf("tbl%0d_data", i), q, tbl[i].exp_q);
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
            chk($sformatf("tbl%0d_nrd", i), 64'(trans_rd), 64'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_nwr", i), 64'(trans_wr), 64'(tbl[i].exp_wr));
            if (tbl[i].exp_rd != 0)
                chk($sformatf("tbl%0d_fill_addr", i), last_rd_addr, tbl[i].addr & ~64'h3F);
            if (tbl[i].exp_wr != 0) begin
                chk($sformatf("tbl%0d_wb_addr", i), last_wb_addr, tbl[i].exp_wb_addr);
                chk($sformatf("tbl%0d_wb_word0", i), last_wb_data[63:0], tbl[i].exp_wb_w0);
            end
        end

        // enable pulsed during a fill must be ignored
        mem_delay = 4;
        predict(0, 64'h3080, 0, 4, eq, elat, erd, ewr);
        @(negedge clk);
        trans_rd = 0;
        trans_wr = 0;
        enable = 1'b1;
        wr_en = 1'b0;
        r_addr = 64'h3080;
        @(posedge clk);
        #1 enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) begin
                enable = 1'b1;
                r_addr = 64'h1000;
            end else begin
                enable = 1'b0;
            end
            if (operation_complete) cnt++;
        end
        chk("ignore_enable_completions", 64'(cnt), 64'd1);
        chk("ignore_enable_data", data_out, eq);
        chk("ignore_enable_nrd", 64'(trans_rd), 64'd1);

        // reset in the middle of a fill aborts it
        mem_delay = 10;
        @(negedge clk);
        trans_rd = 0;
        enable = 1'b1;
        r_addr = 64'h5000;
        @(posedge clk);
        #1 enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midfill_rd_en", 64'(mem_rd_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("midrst_address", mem_address, 64'd0);
        chk("midrst_data_out", data_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (operation_complete) cnt++;
        end
        chk("midrst_no_complete", 64'(cnt), 64'd0);
        mem_delay = 0;
        predict(0, 64'h1000, 0, 0, eq, elat, erd, ewr);
        exec(0, 64'h1000, 0, q, lat);
        chk("postrst_nrd", 64'(trans_rd), 64'd1);
        chk("postrst_data", q, 64'h1234);

        // randomized traffic against the reference model
        for (int i = 0; i < 200; i++) begin
            bit          wr;
            logic [63:0] a, d;
            int          dly;
            wr = 1'($urandom_range(0, 1));
            a = (64'($urandom_range(1, 4)) << 12) | (64'($urandom_range(0, 3)) << 6)
              | (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
            d = {$urandom, $urandom};
            dly = $urandom_range(0, 3);
            mem_delay = dly;
            predict(wr, a, d, dly, eq, elat, erd, ewr);
            exec(wr, a, d, q, lat);
            chk($sformatf("rnd%0d_data", i), q, eq);
            chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(elat));
            chk($sformatf("rnd%0d_nrd", i), 64'(trans_rd), 64'(erd));
            chk($sformatf("rnd%0d_nwr", i), 64'(trans_wr), 64'(ewr));
        end

        chk("mem_req_stable", 64'(stab_err), 64'd0);
        chk("mem_rd_wr_exclusive", 64'(both_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter ADDR_W, default 64, address width in bits.
REQ-002 Parameter WORD_W, default 64, CPU data word width.
REQ-003 Parameter BLOCK_W, default 512, cache line width (64 bytes).
REQ-004 Parameter NUM_SETS, default 64, direct-mapped sets (4 KiB total).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 enable  in  1  request strobe; sampled only in IDLE.
REQ-008 wr_en  in  1  1 = store, 0 = load; sampled with enable.
REQ-009 r_addr  in  ADDR_W  load byte address.
REQ-010 w_addr  in  ADDR_W  store byte address.
REQ-011 data_in  in  WORD_W  store data.
REQ-012 data_out  out  WORD_W  load result, registered.
REQ-013 operation_complete  out  1  one-cycle done pulse.
REQ-014 mem_address  out  ADDR_W  line-aligned memory address.
REQ-015 mem_data_out  out  BLOCK_W  writeback line data.
REQ-016 mem_wr_en  out  1  memory line write request.
REQ-017 mem_rd_en  out  1  memory line read request.
REQ-018 mem_data_in  in  BLOCK_W  fill line data.
REQ-019 mem_data_valid  in  1  memory ack: fill data valid, or writeback accepted.

Function
REQ-020 Address split: [2:0] ignored (word aligned), [5:3] word select, [11:6] set index, [ADDR_W-1:12] tag.
REQ-021 Per set: valid bit, dirty bit, tag, BLOCK_W data; write-back, write-allocate policy.
REQ-022 FSM states: IDLE, WRITEBACK, FILL, RESPOND.
REQ-023 IDLE with enable=1: latch wr_en, selected address (w_addr if wr_en else r_addr), data_in; enable while not IDLE is ignored.
REQ-024 Hit (valid and tag match): load puts selected word on data_out; store writes word into line, sets dirty; operation_complete=1 on the following cycle; FSM goes RESPOND then IDLE.
REQ-025 Miss, victim invalid or clean -> FILL; miss, victim valid and dirty -> WRITEBACK.
REQ-026 WRITEBACK: mem_wr_en=1, mem_address={victim tag, index, 6'b0}, mem_data_out=victim line, held stable until mem_data_valid=1; then clear dirty, go FILL.
REQ-027 FILL: mem_rd_en=1, mem_address={request tag, index, 6'b0} until mem_data_valid=1; then install mem_data_in, set valid, new tag, dirty=0, go RESPOND.
REQ-028 RESPOND: complete the latched load/store against the installed line exactly as a hit (store sets dirty); operation_complete=1 for exactly one cycle; return to IDLE.
REQ-029 Back-to-back: new enable accepted in the cycle after operation_complete.
REQ-030 mem_wr_en and mem_rd_en never both 1; both 0 in IDLE and RESPOND.
REQ-031 data_out holds last load value until the next load completes; stores leave it unchanged.
REQ-032 Hit latency 2 cycles enable->operation_complete; miss latency 2 + memory wait cycles per memory transaction.

Reset
REQ-033 rst=1 asynchronously: FSM to IDLE, all valid and dirty bits cleared, data_out=0, operation_complete=0, mem_wr_en=0, mem_rd_en=0, mem_address=0, mem_data_out=0.
REQ-034 rst mid-operation aborts the transaction; no line, tag or memory write completes; no operation_complete is issued.

Verification
REQ-035 After reset, load r_addr=0x1000 -> mem_rd_en=1, mem_address=0x1000; supply line with word0=0xAAAA -> data_out=0xAAAA, one-cycle operation_complete.
REQ-036 Repeat load 0x1008 (same line, word1=0xBBBB) -> no memory request, data_out=0xBBBB 2 cycles after enable.
REQ-037 Store w_addr=0x1000 data 0x1234, then load 0x2000 (same set 0) -> WRITEBACK with mem_address=0x1000, mem_data_out word0=0x1234, then FILL at 0x2000.
REQ-038 enable pulsed during FILL -> ignored; exactly one operation_complete for the original request.
REQ-039 rst asserted during FILL -> outputs zero immediately; subsequent load 0x1000 misses again.
REQ-040 mem_data_valid delayed 5 cycles -> mem_address/mem_rd_en held stable throughout; completion follows ack by one cycle.
